pipe3_ctrl: RTL and testbench

Flow controller for the 3-stage 8-bit pipeline datapath. It tracks a valid bit per stage and generates per-stage load enables so that stages advance only when downstream has room. It provides a valid/ready handshake on input and output, plus start, drain and flush sequencing and transfer counters for bring-up. Datapath registers are external; this block only controls them.

---
 rtl/pipe3_ctrl_if.sv | 22 ++
 rtl/pipe3_ctrl.sv | 110 +++++++++++
 tb/tb_pipe3_ctrl.sv | 206 ++++++++++++++++++++
 3 files changed

// File: rtl/pipe3_ctrl_if.sv
// Valid/ready handshake bundle for the 3-stage pipeline controller.
// The master side is the upstream/downstream environment; the slave side is the controller.
interface pipe3_ctrl_if;
    logic in_valid;
    logic in_ready;
    logic out_valid;
    logic out_ready;

    modport master (
        output in_valid,
        output out_ready,
        input  in_ready,
        input  out_valid
    );

    modport slave (
        input  in_valid,
        input  out_ready,
        output in_ready,
        output out_valid
    );
endinterface

// File: rtl/pipe3_ctrl.sv
// Flow controller for an external 3-stage 8-bit datapath: per-stage valid tracking,
// load enables, valid/ready handshake, start/drain/flush sequencing and transfer counters.
module pipe3_ctrl #(
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             drain,
    input  logic             flush,
    pipe3_ctrl_if.slave      bus,
    output logic [2:0]       ld_en,
    output logic [2:0]       stage_valid,
    output logic [1:0]       occupancy,
    output logic [1:0]       state,
    output logic             done,
    output logic [CNT_W-1:0] in_count,
    output logic [CNT_W-1:0] out_count
);

    typedef enum logic [1:0] {
        StIdle  = 2'b00,
        StRun   = 2'b01,
        StDrain = 2'b10
    } state_e;

    state_e           state_q, state_d;
    logic [2:0]       valid_q, valid_d;
    logic             done_q, done_d;
    logic [CNT_W-1:0] in_count_q, out_count_q;

    logic t1, t2, t3;
    logic xfer;

    // Room terms, handshake and load enables; flush suppresses every movement.
    always_comb begin
        t3 = !valid_q[2] | bus.out_ready;
        t2 = !valid_q[1] | t3;
        t1 = !valid_q[0] | t2;

        bus.in_ready  = (state_q == StRun) & t1 & !flush;
        bus.out_valid = valid_q[2] & !flush;
        xfer          = bus.out_valid & bus.out_ready;

        ld_en[0] = bus.in_valid & bus.in_ready;
        ld_en[1] = valid_q[0] & t2 & !flush;
        ld_en[2] = valid_q[1] & t3 & !flush;
    end

    // Next-state for valid bits and the sequencing FSM (flush > drain > start).
    always_comb begin
        valid_d = valid_q;
        state_d = state_q;
        done_d  = 1'b0;

        if (flush) begin
            valid_d = 3'b000;
            state_d = StIdle;
        end else begin
            valid_d[0] = ld_en[0] | (valid_q[0] & !t2);
            valid_d[1] = ld_en[1] | (valid_q[1] & !t3);
            valid_d[2] = ld_en[2] | (valid_q[2] & !bus.out_ready);

            case (state_q)
                StIdle: begin
                    if (start) state_d = StRun;
                end
                StRun: begin
                    if (drain) state_d = StDrain;
                end
                StDrain: begin
                    // Leave once the pipe will be empty; done marks the following cycle.
                    if (valid_d == 3'b000) begin
                        state_d = StIdle;
                        done_d  = 1'b1;
                    end
                end
                default: state_d = StIdle;
            endcase
        end
    end

    // State, valid and counter registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            valid_q     <= 3'b000;
            done_q      <= 1'b0;
            in_count_q  <= '0;
            out_count_q <= '0;
        end else begin
            state_q     <= state_d;
            valid_q     <= valid_d;
            done_q      <= done_d;
            in_count_q  <= in_count_q + CNT_W'(ld_en[0]);
            out_count_q <= out_count_q + CNT_W'(xfer);
        end
    end

    // Status outputs derived from registered state.
    always_comb begin
        stage_valid = valid_q;
        occupancy   = {1'b0, valid_q[0]} + {1'b0, valid_q[1]} + {1'b0, valid_q[2]};
        state       = state_q;
        done        = done_q;
        in_count    = in_count_q;
        out_count   = out_count_q;
    end

endmodule

// File: tb/tb_pipe3_ctrl.sv
// Self-checking bench for pipe3_ctrl: directed scenarios plus random traffic, compared
// every cycle against a slot-level model of the pipeline. A second instance with a
// 2-bit counter width checks counter wrap.
module tb_pipe3_ctrl;

    logic clk = 1'b0;
    logic rst, start, drain, flush;
    logic [7:0] in_data;

    logic [2:0]  ld_en, stage_valid, n_ld_en, n_stage_valid;
    logic [1:0]  occupancy, state, n_occupancy, n_state;
    logic        done, n_done;
    logic [15:0] in_count, out_count;
    logic [1:0]  n_in_count, n_out_count;

    pipe3_ctrl_if bus ();
    pipe3_ctrl_if bus_n ();

    assign bus_n.in_valid  = bus.in_valid;
    assign bus_n.out_ready = bus.out_ready;

    pipe3_ctrl #(.CNT_W(16)) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .drain       (drain),
        .flush       (flush),
        .bus         (bus.slave),
        .ld_en       (ld_en),
        .stage_valid (stage_valid),
        .occupancy   (occupancy),
        .state       (state),
        .done        (done),
        .in_count    (in_count),
        .out_count   (out_count)
    );

    pipe3_ctrl #(.CNT_W(2)) dut_n (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .drain       (drain),
        .flush       (flush),
        .bus         (bus_n.slave),
        .ld_en       (n_ld_en),
        .stage_valid (n_stage_valid),
        .occupancy   (n_occupancy),
        .state       (n_state),
        .done        (n_done),
        .in_count    (n_in_count),
        .out_count   (n_out_count)
    );

    always #5 clk = ~clk;

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;

    // Model: each slot holds the byte it carries, or -1 when empty (index 2 = stage 3).
    int          m_slot[3];
    int          m_state;
    logic        m_done;
    int unsigned m_in, m_out;
    logic        m_acc;
    // Bench-side datapath registers, loaded by the DUT's enables.
    logic [7:0]  dp[3];

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s obs=%0h exp=%0h t=%0t", tag, obs, exp, $time);
        end
    endtask

    task automatic step(input logic r, input logic s, input logic dr, input logic fl,
                        input logic iv, input logic [7:0] id, input logic orr);
        int         cur[3];
        int         nxt[3];
        logic [2:0] e_ld, e_sv, obs_ld;
        logic       e_ir, e_ov, e_xfer, empty;
        rst = r; start = s; drain = dr; flush = fl;
        bus.in_valid = iv; in_data = id; bus.out_ready = orr;
        #1;
        cur  = m_slot;
        nxt  = cur;
        e_ld = 3'b000;
        for (int i = 0; i < 3; i++) e_sv[i] = (cur[i] >= 0);
        e_ov   = (cur[2] >= 0) && !fl;
        e_xfer = e_ov && orr;
        if (fl) begin
            nxt = '{-1, -1, -1};
        end else begin
            // Deliver from the last stage, then each item advances one slot into a hole.
            if (e_xfer) nxt[2] = -1;
            if (nxt[2] < 0 && nxt[1] >= 0) begin nxt[2] = nxt[1]; nxt[1] = -1; e_ld[2] = 1'b1; end
            if (nxt[1] < 0 && nxt[0] >= 0) begin nxt[1] = nxt[0]; nxt[0] = -1; e_ld[1] = 1'b1; end
        end
        e_ir = (m_state == 1) && !fl && (nxt[0] < 0);
        if (e_ir && iv) begin nxt[0] = int'(id); e_ld[0] = 1'b1; end

        check_val("in_ready",    bus.in_ready, e_ir);
        check_val("out_valid",   bus.out_valid, e_ov);
        check_val("ld_en",       ld_en, e_ld);
        check_val("stage_valid", stage_valid, e_sv);
        check_val("occupancy",   occupancy, $countones(e_sv));
        check_val("state",       state, m_state);
        check_val("done",        done, m_done);
        check_val("in_count",    in_count, m_in & 32'hFFFF);
        check_val("out_count",   out_count, m_out & 32'hFFFF);
        check_val("n_in_count",  n_in_count, m_in & 32'h3);
        check_val("n_out_count", n_out_count, m_out & 32'h3);
        if (e_xfer) check_val("out_data", dp[2], cur[2]);

        m_acc  = e_ld[0];
        obs_ld = ld_en;

        if (r) begin
            m_slot = '{-1, -1, -1}; m_state = 0; m_done = 1'b0; m_in = 0; m_out = 0;
        end else begin
            m_in  += e_ld[0];
            m_out += e_xfer;
            m_slot = nxt;
            m_done = 1'b0;
            empty  = (nxt[0] < 0) && (nxt[1] < 0) && (nxt[2] < 0);
            if (fl) m_state = 0;
            else if (m_state == 0 && s) m_state = 1;
            else if (m_state == 1 && dr) m_state = 2;
            else if (m_state == 2 && empty) begin m_state = 0; m_done = 1'b1; end
        end

        @(posedge clk);
        if (obs_ld[2]) dp[2] = dp[1];
        if (obs_ld[1]) dp[1] = dp[0];
        if (obs_ld[0]) dp[0] = id;
        @(negedge clk);
    endtask

    task automatic idle(input int n, input logic orr);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, orr);
    endtask

    // Offer bytes from 'first' upwards until 'cnt' are accepted or the cycle budget runs out.
    task automatic offer(input int cnt, input logic [7:0] first, input logic orr, input int budget);
        int k = 0;
        for (int c = 0; c < budget && k < cnt; c++) begin
            step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, first + 8'(k), orr);
            if (m_acc) k++;
        end
    endtask

    logic [7:0] stream[8] = '{8'hAA, 8'hCC, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06};

    initial begin
        m_slot = '{-1, -1, -1}; m_state = 0; m_done = 1'b0; m_in = 0; m_out = 0; m_acc = 1'b0;
        dp = '{8'h00, 8'h00, 8'h00};
        rst = 1'b1; start = 1'b0; drain = 1'b0; flush = 1'b0;
        bus.in_valid = 1'b0; bus.out_ready = 1'b0; in_data = 8'h00;
        @(posedge clk);
        @(negedge clk);

        // Reset held, then idle with in_valid asserted but no start.
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 8'h11, 1'b0);
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'h11, 1'b0);
        step(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 8'h11, 1'b0);

        // Streaming at full throughput.
        step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 1'b1);
        for (int i = 0; i < 8; i++) step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, stream[i], 1'b1);
        idle(4, 1'b1);

        // Backpressure: 5 offered with a stalled sink, then released.
        offer(5, 8'h40, 1'b0, 5);
        idle(2, 1'b0);
        offer(2, 8'h43, 1'b1, 6);
        idle(4, 1'b1);

        // Drain with three in flight.
        offer(3, 8'h50, 1'b0, 6);
        step(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 8'h5F, 1'b1);
        for (int i = 0; i < 5; i++) step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'h5E, 1'b1);

        // Flush takes priority over drain.
        step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
        offer(3, 8'h60, 1'b0, 6);
        step(1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 8'h6F, 1'b1);
        idle(3, 1'b1);

        // Reset during a stalled, full pipe.
        step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
        offer(3, 8'h70, 1'b0, 6);
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 8'h7F, 1'b0);
        idle(2, 1'b1);

        // Random traffic.
        for (int i = 0; i < 3000; i++) begin
            step($urandom_range(0, 299) == 0, $urandom_range(0, 3) == 0,
                 $urandom_range(0, 29) == 0, $urandom_range(0, 59) == 0,
                 1'($urandom_range(0, 1)), 8'($urandom), $urandom_range(0, 2) != 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
